// File: rtl/mmio_demux_pkg.sv
// Shared definitions for the MMIO demultiplexer: region encoding,
// region address windows and GPIO register offsets.
package mmio_demux_pkg;

  typedef enum logic [1:0] {
    RGN_DM   = 2'd0,
    RGN_ACC  = 2'd1,
    RGN_GPIO = 2'd2,
    RGN_NONE = 2'd3
  } region_e;

  // Region windows, expressed on the low 12 address bits. Any set bit
  // above bit 11 places an address outside every window.
  localparam logic [11:0] DM_BASE    = 12'h000;
  localparam logic [11:0] DM_LIMIT   = 12'h7FF;
  localparam logic [11:0] ACC_BASE   = 12'h800;
  localparam logic [11:0] ACC_LIMIT  = 12'h8FF;
  localparam logic [11:0] GPIO_BASE  = 12'h900;
  localparam logic [11:0] GPIO_LIMIT = 12'h9FF;

  // Word offsets inside the GPIO window.
  localparam logic [7:0] GPIO_OFF_GPI    = 8'h00;
  localparam logic [7:0] GPIO_OFF_GPO    = 8'h08;
  localparam logic [7:0] GPIO_OFF_STATUS = 8'h0C;

  // Inclusive window test on the low address bits.
  function automatic logic in_window(input logic [11:0] a,
                                     input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Purely combinational address decoder: CPU byte address in, region out.
// Window limits all end on a word boundary, so addr[1:0] never changes
// the outcome.
module mmio_addr_decode
  import mmio_demux_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output region_e               region
);

  logic [11:0] addr_lo;
  logic        addr_hi_nz;

  // Classify the address into one of the four regions.
  always_comb begin
    addr_lo    = addr[11:0];
    addr_hi_nz = |addr[ADDR_WIDTH-1:12];
    region     = RGN_NONE;
    if (!addr_hi_nz) begin
      if (in_window(addr_lo, DM_BASE, DM_LIMIT)) begin
        region = RGN_DM;
      end else if (in_window(addr_lo, ACC_BASE, ACC_LIMIT)) begin
        region = RGN_ACC;
      end else if (in_window(addr_lo, GPIO_BASE, GPIO_LIMIT)) begin
        region = RGN_GPIO;
      end
    end
  end

endmodule

// File: rtl/mmio_demux.sv
// CPU-side MMIO demultiplexer: routes stores to data memory, accelerator
// or the local GPIO block, and returns load data with a fixed one-cycle
// latency for every region. Owns the GPIO registers and a sticky error
// flag for accesses that hit no region.
module mmio_demux
  import mmio_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  we_dm,
  output logic                  we_acc,
  input  logic [DATA_WIDTH-1:0] dm_rd,
  input  logic [DATA_WIDTH-1:0] acc_rd,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic                  err
);

  region_e               region;
  logic [7:0]            gpio_off;
  logic                  gpio_wr;
  logic                  err_set;
  logic                  err_clr;

  logic [DATA_WIDTH-1:0] sync1_d,   sync1_q;
  logic [DATA_WIDTH-1:0] sync2_d,   sync2_q;
  logic [DATA_WIDTH-1:0] gpo_d,     gpo_q;
  logic                  err_d,     err_q;
  region_e               rd_sel_d,  rd_sel_q;
  logic [DATA_WIDTH-1:0] rd_gpio_d, rd_gpio_q;

  mmio_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .addr   (addr),
    .region (region)
  );

  // Same-cycle write strobes and GPIO register selection.
  always_comb begin
    we_dm    = we && (region == RGN_DM);
    we_acc   = we && (region == RGN_ACC);
    gpio_off = {addr[7:2], 2'b00};
    gpio_wr  = we && (region == RGN_GPIO);
  end

  // Next-state for synchronizer, GPIO registers, error flag and read path.
  always_comb begin
    sync1_d = gpio_in;
    sync2_d = sync1_q;

    gpo_d = gpo_q;
    if (gpio_wr && (gpio_off == GPIO_OFF_GPO)) begin
      gpo_d = wd;
    end

    // Every cycle counts as a read, so an unmapped address always sets
    // the flag. Set has priority over a STATUS clear.
    err_set = (region == RGN_NONE);
    err_clr = gpio_wr && (gpio_off == GPIO_OFF_STATUS) && wd[0];
    err_d   = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end

    rd_sel_d = region;

    // Read value is taken from current (pre-write) register contents.
    rd_gpio_d = '0;
    if (region == RGN_GPIO) begin
      case (gpio_off)
        GPIO_OFF_GPI:    rd_gpio_d    = sync2_q;
        GPIO_OFF_GPO:    rd_gpio_d    = gpo_q;
        GPIO_OFF_STATUS: rd_gpio_d[0] = err_q;
        default:         rd_gpio_d    = '0;
      endcase
    end
  end

  // State registers; reset drops any pending read and any GPIO store.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      gpo_q     <= '0;
      err_q     <= 1'b0;
      rd_sel_q  <= RGN_NONE;
      rd_gpio_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      gpo_q     <= gpo_d;
      err_q     <= err_d;
      rd_sel_q  <= rd_sel_d;
      rd_gpio_q <= rd_gpio_d;
    end
  end

  // Load data return, steered by the region registered last cycle.
  always_comb begin
    rd = '0;
    case (rd_sel_q)
      RGN_DM:   rd = dm_rd;
      RGN_ACC:  rd = acc_rd;
      RGN_GPIO: rd = rd_gpio_q;
      default:  rd = '0;
    endcase
    gpio_out = gpo_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_mmio_demux.sv
// Bench for mmio_demux: table of single-cycle accesses with a scoreboard
// of next-cycle expectations, plus hand sequences for the synchronizer
// and mid-operation reset.
module tb_mmio_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        we_dm;
  logic        we_acc;
  logic [31:0] dm_rd;
  logic [31:0] acc_rd;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        err;

  always #5 clk = ~clk;

  mmio_demux #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .wd       (wd),
    .rd       (rd),
    .we_dm    (we_dm),
    .we_acc   (we_acc),
    .dm_rd    (dm_rd),
    .acc_rd   (acc_rd),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .err      (err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_we_dm;
    logic        exp_we_acc;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_gpo;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [31:0] gpo;
  } exp_t;

  vec_t        vq[$];
  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] prev_addr;

  localparam logic [31:0] GPI_VAL = 32'h5A5A_0001;
  localparam logic [31:0] GPO_VAL = 32'hA5A5_0F0F;

  // Peripheral models: read data depends on the address of the prior cycle.
  function automatic logic [31:0] dm_model(input logic [31:0] a);
    if (a[31:2] == 30'h1) return 32'h0000_1234;
    return 32'hD000_0000 | a;
  endfunction

  function automatic logic [31:0] acc_model(input logic [31:0] a);
    return 32'hACC0_0000 | a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic wdm, input logic wacc, input logic [31:0] r,
                     input logic e, input logic [31:0] g);
    vq.push_back('{w, a, d, wdm, wacc, r, e, g});
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    dm_rd     = dm_model(prev_addr);
    acc_rd    = acc_model(prev_addr);
    we        = w;
    addr      = a;
    wd        = d;
    prev_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; we = 1'b0; addr = '0; wd = '0;
    dm_rd = '0; acc_rd = '0; gpio_in = GPI_VAL; prev_addr = '0;

    //   we    addr            wd            we_dm we_acc rd_next        err  gpio_out
    add(1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'hD000_0000, 1'b0, 32'h0);
    add(1'b1, 32'h0000_0004, 32'h11,        1'b1, 1'b0, 32'h0000_1234, 1'b0, 32'h0);
    add(1'b1, 32'h0000_0804, 32'h22,        1'b0, 1'b1, 32'hACC0_0804, 1'b0, 32'h0);
    add(1'b0, 32'h0000_0004, 32'h0,         1'b0, 1'b0, 32'h0000_1234, 1'b0, 32'h0);
    add(1'b0, 32'h0000_0900, 32'h0,         1'b0, 1'b0, GPI_VAL,       1'b0, 32'h0);
    add(1'b1, 32'h0000_0908, GPO_VAL,       1'b0, 1'b0, 32'h0,         1'b0, GPO_VAL);
    add(1'b0, 32'h0000_0908, 32'h0,         1'b0, 1'b0, GPO_VAL,       1'b0, GPO_VAL);
    add(1'b1, 32'h0000_0900, 32'hFFFF_FFFF, 1'b0, 1'b0, GPI_VAL,       1'b0, GPO_VAL);
    add(1'b1, 32'h0000_0904, 32'h1,         1'b0, 1'b0, 32'h0,         1'b0, GPO_VAL);
    add(1'b0, 32'h0000_090C, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, GPO_VAL);
    add(1'b0, 32'h0000_1000, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, GPO_VAL);
    add(1'b0, 32'h0000_090C, 32'h0,         1'b0, 1'b0, 32'h1,         1'b1, GPO_VAL);
    add(1'b1, 32'h0000_090C, 32'h0,         1'b0, 1'b0, 32'h1,         1'b1, GPO_VAL);
    add(1'b1, 32'h0000_090C, 32'h1,         1'b0, 1'b0, 32'h1,         1'b0, GPO_VAL);
    add(1'b0, 32'h0000_090C, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, GPO_VAL);
    add(1'b1, 32'h0000_0A00, 32'h1,         1'b0, 1'b0, 32'h0,         1'b1, GPO_VAL);
    add(1'b0, 32'h0000_08FF, 32'h0,         1'b0, 1'b0, 32'hACC0_08FF, 1'b1, GPO_VAL);
    add(1'b0, 32'h0000_07FC, 32'h0,         1'b0, 1'b0, 32'hD000_07FC, 1'b1, GPO_VAL);
    add(1'b1, 32'h0000_07FF, 32'h5,         1'b1, 1'b0, 32'hD000_07FF, 1'b1, GPO_VAL);
    add(1'b1, 32'h0000_0800, 32'h6,         1'b0, 1'b1, 32'hACC0_0800, 1'b1, GPO_VAL);
    add(1'b1, 32'h0000_09FF, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, GPO_VAL);
    add(1'b1, 32'h8000_0908, 32'h7,         1'b0, 1'b0, 32'h0,         1'b1, GPO_VAL);
    add(1'b0, 32'h0000_090B, 32'h0,         1'b0, 1'b0, GPO_VAL,       1'b1, GPO_VAL);
    add(1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 32'hD000_0008, 1'b1, GPO_VAL);
    add(1'b0, 32'h0000_0808, 32'h0,         1'b0, 1'b0, 32'hACC0_0808, 1'b1, GPO_VAL);
    add(1'b0, 32'h0000_0900, 32'h0,         1'b0, 1'b0, GPI_VAL,       1'b1, GPO_VAL);
    add(1'b0, 32'h0000_2000, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, GPO_VAL);

    // Reset state
    repeat (3) tick();
    chk("reset_rd", rd, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_gpio_out", gpio_out, 32'h0);
    rst = 1'b0;
    repeat (3) begin
      drive(1'b0, 32'h0, 32'h0);
      tick();
    end

    // Table: strobes checked in-cycle, read/err/gpio_out checked next cycle
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].we, vq[i].addr, vq[i].wd);
      #1;
      chk($sformatf("we_dm[%0d]", i), {31'h0, we_dm}, {31'h0, vq[i].exp_we_dm});
      chk($sformatf("we_acc[%0d]", i), {31'h0, we_acc}, {31'h0, vq[i].exp_we_acc});
      if (i > 0) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard[%0d]: got empty queue, want one entry", i);
        end else begin
          e = sb.pop_front();
          chk($sformatf("rd[%0d]", i - 1), rd, e.rd);
          chk($sformatf("err[%0d]", i - 1), {31'h0, err}, {31'h0, e.err});
          chk($sformatf("gpio_out[%0d]", i - 1), gpio_out, e.gpo);
        end
      end
      sb.push_back('{vq[i].exp_rd, vq[i].exp_err, vq[i].exp_gpo});
      tick();
    end
    drive(1'b0, 32'h0000_0900, 32'h0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd[last]", rd, e.rd);
      chk("err[last]", {31'h0, err}, {31'h0, e.err});
      chk("gpio_out[last]", gpio_out, e.gpo);
    end
    tick();

    // Synchronizer: change just after edge E0, reads sampled at E2 and E3
    gpio_in = 32'h0;
    repeat (4) tick();
    gpio_in = 32'h0000_00FF;
    tick();
    tick();
    chk("sync_edge2", rd, 32'h0);
    tick();
    chk("sync_edge3", rd, 32'h0000_00FF);

    // Reset mid-operation with a GPO store and GPO read in the reset cycle
    drive(1'b1, 32'h0000_0908, 32'hFFFF_FFFF);
    tick();
    chk("pre_rst_gpio_out", gpio_out, 32'hFFFF_FFFF);
    drive(1'b0, 32'h0000_1000, 32'h0);
    tick();
    chk("pre_rst_err", {31'h0, err}, 32'h1);
    drive(1'b1, 32'h0000_0908, 32'h0000_1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_rd", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
